hessian_deriv_gen: RTL and testbench

- Streaming producer of the second-order derivatives consumed by the edge-rejection stage: odxx/odyy/odxy feed its idxx/idyy/idxy directly.
- Accepts one raster-order signed DoG pixel per valid cycle and keeps two line buffers plus a 3x3 window.
- Emits saturated 9-bit signed dxx, dyy and dxy for every interior pixel, with the centre coordinates and a valid strobe.
- Sits between the DoG scale-space output and the edge / keypoint qualification logic.

---
 rtl/hessian_deriv_gen.sv | 191 +++++++++++++++++++
 tb/tb_hessian_deriv_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hessian_deriv_gen.sv
// Streaming 3x3 Hessian generator: takes raster-order signed DoG pixels and
// emits saturated dxx/dyy and floored dxy for every interior centre, two cycles after the pixel that completes it.
module hessian_deriv_gen #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned CW    = 10
) (
   input  logic          iclk,
   input  logic          irst_n,
   input  logic          ivalid,
   input  logic          isof,
   input  logic [7:0]    idog,
   output logic          ovalid,
   output logic [8:0]    odxx,
   output logic [8:0]    odyy,
   output logic [8:0]    odxy,
   output logic [CW-1:0] ox,
   output logic [CW-1:0] oy
);
   localparam int unsigned PW  = 8;
   localparam int unsigned AW  = 10;
   localparam int unsigned OW  = 9;
   localparam int unsigned LBW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic signed [AW-1:0] SMAX = 10'sd255;
   localparam logic signed [AW-1:0] SMIN = -10'sd256;

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_e;

   state_e         state_q, state_d;
   logic           accept_c, last_c, elig_c;
   logic [CW-1:0]  px_c, py_c;
   logic [CW-1:0]  x_q, x_d, y_q, y_d;
   logic [LBW-1:0] la_c;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ivalid && isof)          state_d = ACTIVE;
      else if (accept_c && last_c) state_d = DONE;
   end

   // A start-of-frame pixel is always taken as (0,0), whatever the state.
   always_comb begin
      accept_c = ivalid && (isof || (state_q == ACTIVE));
      px_c     = isof ? '0 : x_q;
      py_c     = isof ? '0 : y_q;
      last_c   = (px_c == CW'(IMG_W - 1)) && (py_c == CW'(IMG_H - 1));
      elig_c   = accept_c && (px_c >= CW'(2)) && (py_c >= CW'(2));
      la_c     = LBW'(px_c);
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (accept_c) begin
         if (px_c == CW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (py_c == CW'(IMG_H - 1)) ? '0 : py_c + CW'(1);
         end else begin
            x_d = px_c + CW'(1);
            y_d = py_c;
         end
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   logic [PW-1:0] lb1_q [IMG_W];
   logic [PW-1:0] lb2_q [IMG_W];

   always_ff @(posedge iclk) begin
      if (accept_c) begin
         lb2_q[la_c] <= lb1_q[la_c];
         lb1_q[la_c] <= idog;
      end
   end

   // Column stage: {row y-2, row y-1, row y} plus centre coordinates.
   logic          col_v_q, col_e_q;
   logic [PW-1:0] col_q [3];
   logic [CW-1:0] col_x_q, col_y_q;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         col_v_q <= 1'b0;
         col_e_q <= 1'b0;
         col_x_q <= '0;
         col_y_q <= '0;
         for (int r = 0; r < 3; r++) col_q[r] <= '0;
      end else begin
         col_v_q <= accept_c;
         if (accept_c) begin
            col_e_q <= elig_c;
            col_q[0] <= lb2_q[la_c];
            col_q[1] <= lb1_q[la_c];
            col_q[2] <= idog;
            col_x_q <= px_c - CW'(1);
            col_y_q <= py_c - CW'(1);
         end
      end
   end

   // Window stage: rows up/centre/down, columns left/centre/right.
   logic [PW-1:0] win_q [3][3];
   logic          win_v_q;
   logic [CW-1:0] win_x_q, win_y_q;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         win_v_q <= 1'b0;
         win_x_q <= '0;
         win_y_q <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end else begin
         win_v_q <= col_v_q && col_e_q;
         if (col_v_q) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
               win_q[r][2] <= col_q[r];
            end
            win_x_q <= col_x_q;
            win_y_q <= col_y_q;
         end
      end
   end

   function automatic logic signed [AW-1:0] sx(input logic [PW-1:0] v);
      return {{(AW-PW){v[PW-1]}}, v};
   endfunction

   function automatic logic [OW-1:0] sat(input logic signed [AW-1:0] v);
      if (v > SMAX)      return 9'h0FF;
      else if (v < SMIN) return 9'h100;
      else               return OW'(v);
   endfunction

   logic signed [AW-1:0] dxx_c, dyy_c, dxy_sum_c, dxy_sh_c;

   always_comb begin
      dxx_c     = sx(win_q[1][0]) + sx(win_q[1][2]) - (sx(win_q[1][1]) <<< 1);
      dyy_c     = sx(win_q[0][1]) + sx(win_q[2][1]) - (sx(win_q[1][1]) <<< 1);
      dxy_sum_c = sx(win_q[2][2]) + sx(win_q[0][0]) - sx(win_q[0][2]) - sx(win_q[2][0]);
      dxy_sh_c  = dxy_sum_c >>> 2;
   end

   logic          ovalid_q;
   logic [OW-1:0] dxx_q, dyy_q, dxy_q;
   logic [CW-1:0] ox_q, oy_q;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         ovalid_q <= 1'b0;
         dxx_q    <= '0;
         dyy_q    <= '0;
         dxy_q    <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
      end else begin
         ovalid_q <= win_v_q;
         if (win_v_q) begin
            dxx_q <= sat(dxx_c);
            dyy_q <= sat(dyy_c);
            dxy_q <= OW'(dxy_sh_c);
            ox_q  <= win_x_q;
            oy_q  <= win_y_q;
         end
      end
   end

   assign ovalid = ovalid_q;
   assign odxx   = dxx_q;
   assign odyy   = dyy_q;
   assign odxy   = dxy_q;
   assign ox     = ox_q;
   assign oy     = oy_q;

endmodule

// File: tb/tb_hessian_deriv_gen.sv
// Directed bench for hessian_deriv_gen on an 8x6 frame: scoreboard built from
// the image at accept time, plus hand-computed spot values.
module tb_hessian_deriv_gen;
   localparam int unsigned W  = 8;
   localparam int unsigned H  = 6;
   localparam int unsigned CW = 10;

   logic          iclk = 1'b0;
   logic          irst_n;
   logic          ivalid, isof;
   logic [7:0]    idog;
   logic          ovalid;
   logic [8:0]    odxx, odyy, odxy;
   logic [CW-1:0] ox, oy;

   hessian_deriv_gen #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
      .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isof(isof), .idog(idog),
      .ovalid(ovalid), .odxx(odxx), .odyy(odyy), .odxy(odxy), .ox(ox), .oy(oy)
   );

   always #5 iclk = ~iclk;

   typedef struct { int x; int y; int dxx; int dyy; int dxy; int cyc; } rec_t;

   rec_t got[$];
   rec_t exp_q[$];
   int   img [H][W];
   int   acc_cyc [H][W];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always @(posedge iclk) cyc <= cyc + 1;

   always @(negedge iclk) begin
      if (ovalid === 1'b1) begin
         rec_t r;
         r.x = int'(ox); r.y = int'(oy);
         r.dxx = int'($signed(odxx)); r.dyy = int'($signed(odyy)); r.dxy = int'($signed(odxy));
         r.cyc = cyc;
         got.push_back(r);
      end
   end

   task automatic chk(input string tag, input int obs, input int expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
   endtask

   function automatic int clamp9(input int v);
      return (v > 255) ? 255 : ((v < -256) ? -256 : v);
   endfunction

   function automatic int find(input int x, input int y);
      foreach (got[i]) if (got[i].x == x && got[i].y == y) return i;
      return -1;
   endfunction

   // sel: 0 = dxx, 1 = dyy, 2 = dxy
   task automatic hchk(input string tag, input int x, input int y, input int sel, input int expv);
      int i, v;
      i = find(x, y);
      v = -9999;
      if (i >= 0) v = (sel == 0) ? got[i].dxx : ((sel == 1) ? got[i].dyy : got[i].dxy);
      chk(tag, v, expv);
   endtask

   task automatic fill(input int v);
      foreach (img[y, x]) img[y][x] = v;
   endtask

   task automatic send_pix(input int x, input int y, input bit sof, input int pct);
      while (int'($urandom_range(99)) < pct) begin
         ivalid = 1'b0; isof = 1'b0;
         @(posedge iclk); #1;
      end
      ivalid = 1'b1; isof = sof; idog = 8'(img[y][x]);
      acc_cyc[y][x] = cyc + 1;
      if (x >= 2 && y >= 2) begin
         rec_t e;
         e.x = x - 1; e.y = y - 1;
         e.dxx = clamp9(img[y-1][x-2] + img[y-1][x] - 2 * img[y-1][x-1]);
         e.dyy = clamp9(img[y-2][x-1] + img[y][x-1] - 2 * img[y-1][x-1]);
         e.dxy = (img[y][x] + img[y-2][x-2] - img[y-2][x] - img[y][x-2]) >>> 2;
         e.cyc = cyc + 3;
         exp_q.push_back(e);
      end
      @(posedge iclk); #1;
      ivalid = 1'b0; isof = 1'b0;
   endtask

   task automatic send_frame(input int npix, input int pct);
      for (int i = 0; i < npix; i++) send_pix(i % W, i / W, i == 0, pct);
   endtask

   task automatic send_junk(input int n);
      for (int i = 0; i < n; i++) begin
         ivalid = 1'b1; isof = 1'b0; idog = 8'($urandom_range(255));
         @(posedge iclk); #1;
      end
      ivalid = 1'b0;
   endtask

   task automatic cmp_queues(input string tag);
      int n;
      repeat (6) @(posedge iclk);
      #1;
      chk({tag, "_count"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_x"},   got[i].x,   exp_q[i].x);
         chk({tag, "_y"},   got[i].y,   exp_q[i].y);
         chk({tag, "_dxx"}, got[i].dxx, exp_q[i].dxx);
         chk({tag, "_dyy"}, got[i].dyy, exp_q[i].dyy);
         chk({tag, "_dxy"}, got[i].dxy, exp_q[i].dxy);
         chk({tag, "_cyc"}, got[i].cyc, exp_q[i].cyc);
      end
   endtask

   task automatic clr();
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int rst_cyc;
      irst_n = 1'b0; ivalid = 1'b0; isof = 1'b0; idog = '0;
      repeat (3) @(posedge iclk);
      #1;
      chk("rst_ovalid", ovalid, 0);
      chk("rst_dxx", odxx, 0);
      chk("rst_dyy", odyy, 0);
      chk("rst_dxy", odxy, 0);
      chk("rst_ox", ox, 0);
      chk("rst_oy", oy, 0);
      irst_n = 1'b1;
      @(posedge iclk); #1;

      // Pixels before any start-of-frame are dropped.
      send_junk(20);

      // Constant image, continuous input.
      clr(); fill(20);
      send_frame(W * H, 0);
      cmp_queues("const");
      chk("const_n", got.size(), 24);
      chk("const_first_x", (got.size() > 0) ? got[0].x : -1, 1);
      chk("const_first_y", (got.size() > 0) ? got[0].y : -1, 1);
      chk("const_first_lat", (got.size() > 0) ? got[0].cyc - acc_cyc[2][2] : -1, 2);
      chk("const_first_dxx", (got.size() > 0) ? got[0].dxx : -1, 0);
      chk("const_last_x", (got.size() > 0) ? got[got.size()-1].x : -1, 6);
      chk("const_last_y", (got.size() > 0) ? got[got.size()-1].y : -1, 4);

      // Impulse of 100 at (3,3).
      clr(); fill(0); img[3][3] = 100;
      send_frame(W * H, 0);
      cmp_queues("imp");
      hchk("imp_c_dxx", 3, 3, 0, -200);
      hchk("imp_c_dyy", 3, 3, 1, -200);
      hchk("imp_c_dxy", 3, 3, 2, 0);
      hchk("imp_l_dxx", 2, 3, 0, 100);
      hchk("imp_l_dyy", 2, 3, 1, 0);
      hchk("imp_ul_dxy", 2, 2, 2, 25);

      // Saturation at both rails.
      clr(); fill(0);
      img[2][2] = -128; img[2][1] = 127; img[2][3] = 127;
      img[2][5] = 127;  img[1][5] = -128; img[3][5] = -128;
      send_frame(W * H, 0);
      cmp_queues("sat");
      hchk("sat_dxx_hi", 2, 2, 0, 255);
      hchk("sat_dyy_lo", 5, 2, 1, -256);

      // Mixed-derivative scaling and floor rounding.
      clr(); fill(0);
      img[3][3] = 100; img[1][1] = 100; img[1][3] = -100; img[3][1] = -100;
      img[3][6] = -5;
      send_frame(W * H, 0);
      cmp_queues("dxy");
      hchk("dxy_full", 2, 2, 2, 100);
      hchk("dxy_floor", 5, 2, 2, -2);

      // Random bubbles, then trailing pixels after frame end.
      clr(); fill(20);
      send_frame(W * H, 50);
      send_junk(16);
      cmp_queues("bub");
      chk("bub_n", got.size(), 24);

      // Start-of-frame in row 3: old outputs drain, new frame is clean.
      clr(); fill(0); img[3][3] = 100;
      send_frame(W * 3 + 4, 0);
      fill(20);
      send_frame(W * H, 0);
      cmp_queues("restart");
      chk("restart_n", got.size(), 8 + 24);

      // Reset mid-frame after pixel (5,3).
      clr(); fill(0); img[3][3] = 100;
      send_frame(W * 3 + 6, 0);
      chk("prerst_ovalid", ovalid, 1);
      irst_n = 1'b0;
      rst_cyc = cyc;
      #1;
      chk("midrst_ovalid", ovalid, 0);
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= rst_cyc) void'(exp_q.pop_back());
      @(posedge iclk); #1;
      irst_n = 1'b1;
      send_junk(30);
      cmp_queues("rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
